// File: rtl/spi_word_receiver_if.sv
// Handshake and serial-input bundle between the input conditioners, the
// word receiver and its downstream consumer.
interface spi_word_receiver_if #(
  parameter int width      = 8,
  parameter int countwidth = 8
);
  logic                  sclk_posedge;
  logic                  cs_n;
  logic                  mosi;
  logic                  data_ready;
  logic [width-1:0]      data_out;
  logic                  data_valid;
  logic                  frame_active;
  logic [countwidth-1:0] word_count;
  logic                  overrun;
  logic                  framing_error;

  modport master (
    output sclk_posedge, cs_n, mosi, data_ready,
    input  data_out, data_valid, frame_active, word_count, overrun, framing_error
  );

  modport slave (
    input  sclk_posedge, cs_n, mosi, data_ready,
    output data_out, data_valid, frame_active, word_count, overrun, framing_error
  );
endinterface

// File: rtl/spi_word_receiver.sv
// Assembles MSB-first words from conditioned serial inputs within a chip-select
// frame and offers them on a valid/ready port with overrun/framing flags.
module spi_word_receiver #(
  parameter int width      = 8,
  parameter int countwidth = 8
) (
  input  logic              clk,
  input  logic              reset,
  spi_word_receiver_if.slave bus
);
  localparam int BW = (width > 1) ? $clog2(width) : 1;
  localparam logic [BW-1:0] LastBit = BW'(width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [width-1:0]      shiftReg_q, shiftReg_d;
  logic [BW-1:0]         bitCnt_q, bitCnt_d;
  logic [width-1:0]      dataOut_q, dataOut_d;
  logic                  dataValid_q, dataValid_d;
  logic [countwidth-1:0] wordCount_q, wordCount_d;
  logic                  overrun_q, overrun_d;
  logic                  framingErr_q, framingErr_d;
  logic [width-1:0]      shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shiftReg_q   <= '0;
      bitCnt_q     <= '0;
      dataOut_q    <= '0;
      dataValid_q  <= 1'b0;
      wordCount_q  <= '0;
      overrun_q    <= 1'b0;
      framingErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shiftReg_q   <= shiftReg_d;
      bitCnt_q     <= bitCnt_d;
      dataOut_q    <= dataOut_d;
      dataValid_q  <= dataValid_d;
      wordCount_q  <= wordCount_d;
      overrun_q    <= overrun_d;
      framingErr_q <= framingErr_d;
    end
  end

  assign shifted = {shiftReg_q[width-2:0], bus.mosi};

  always_comb begin
    state_d      = state_q;
    shiftReg_d   = shiftReg_q;
    bitCnt_d     = bitCnt_q;
    dataOut_d    = dataOut_q;
    dataValid_d  = dataValid_q;
    wordCount_d  = wordCount_q;
    overrun_d    = overrun_q;
    framingErr_d = 1'b0;

    if (dataValid_q && bus.data_ready) begin
      dataValid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!bus.cs_n) begin
          state_d     = SHIFT;
          bitCnt_d    = '0;
          wordCount_d = '0;
        end
      end
      SHIFT: begin
        // A chip-select rise wins over a coincident serial-clock pulse.
        if (bus.cs_n) begin
          state_d = IDLE;
          if (bitCnt_q != '0) begin
            framingErr_d = 1'b1;
            shiftReg_d   = '0;
            bitCnt_d     = '0;
          end
        end else if (bus.sclk_posedge) begin
          shiftReg_d = shifted;
          if (bitCnt_q == LastBit) begin
            bitCnt_d = '0;
            if (wordCount_q != '1) begin
              wordCount_d = wordCount_q + 1'b1;
            end
            if (!dataValid_q || bus.data_ready) begin
              dataOut_d   = shifted;
              dataValid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out      = dataOut_q;
  assign bus.data_valid    = dataValid_q;
  assign bus.frame_active  = (state_q == SHIFT);
  assign bus.word_count    = wordCount_q;
  assign bus.overrun       = overrun_q;
  assign bus.framing_error = framingErr_q;
endmodule

// File: tb/tb_spi_word_receiver.sv
// Self-checking bench for spi_word_receiver: table-driven single frames plus
// hand-written back-to-back, overrun, simultaneous-accept and reset sequences.
module tb_spi_word_receiver;
  logic clk = 1'b0;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] sbQueue[$];

  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [7:0] prevData  = '0;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       expFE;
    logic [7:0] expCount;
  } vec_t;

  vec_t vecs[5];

  spi_word_receiver_if #(.width(8), .countwidth(8)) bus();

  spi_word_receiver #(.width(8), .countwidth(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Consumer side: every transfer must match the oldest expected word, and a
  // held word must not change until it is taken.
  always @(negedge clk) begin
    if (reset) begin
      prevValid <= 1'b0;
    end else begin
      if (prevValid && !prevReady) begin
        checkOutput("held_valid", 32'(bus.data_valid), 32'd1);
        checkOutput("held_data", 32'(bus.data_out), 32'(prevData));
      end
      if (bus.data_valid && bus.data_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_transfer", 32'(bus.data_out), 32'hFFFF_FFFF);
        end else begin
          checkOutput("transfer_data", 32'(bus.data_out), 32'(sbQueue.pop_front()));
        end
      end
      prevValid <= bus.data_valid;
      prevReady <= bus.data_ready;
      prevData  <= bus.data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b);
    bus.sclk_posedge = 1'b1;
    bus.mosi         = b;
    tick();
    bus.sclk_posedge = 1'b0;
    tick();
  endtask

  task automatic sendBits(input logic [7:0] data, input int nbits);
    for (int i = 0; i < nbits; i++) applyStimulus(data[7-i]);
  endtask

  task automatic resetDut();
    reset            = 1'b1;
    bus.cs_n         = 1'b1;
    bus.sclk_posedge = 1'b0;
    bus.mosi         = 1'b0;
    bus.data_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic startFrame();
    bus.cs_n = 1'b0;
    tick();
    checkOutput("frame_active_start", 32'(bus.frame_active), 32'd1);
  endtask

  task automatic endFrame(input logic expFE);
    bus.cs_n = 1'b1;
    tick();
    checkOutput("framing_error_pulse", 32'(bus.framing_error), 32'(expFE));
    checkOutput("frame_active_end", 32'(bus.frame_active), 32'd0);
    tick();
    checkOutput("framing_error_clear", 32'(bus.framing_error), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
    checkOutput({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
    checkOutput({tag, "_frame_active"}, 32'(bus.frame_active), 32'd0);
    checkOutput({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    checkOutput({tag, "_framing_error"}, 32'(bus.framing_error), 32'd0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, nbits: 8, expFE: 1'b0, expCount: 8'd1};
    vecs[1] = '{data: 8'hB0, nbits: 5, expFE: 1'b1, expCount: 8'd0};
    vecs[2] = '{data: 8'hFF, nbits: 8, expFE: 1'b0, expCount: 8'd1};
    vecs[3] = '{data: 8'h00, nbits: 8, expFE: 1'b0, expCount: 8'd1};
    vecs[4] = '{data: 8'h60, nbits: 3, expFE: 1'b1, expCount: 8'd0};

    resetDut();
    checkAllZero("reset");

    // Single frames with a ready consumer.
    bus.data_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].nbits == 8) sbQueue.push_back(vecs[v].data);
      startFrame();
      sendBits(vecs[v].data, vecs[v].nbits);
      endFrame(vecs[v].expFE);
      checkOutput("vec_word_count", 32'(bus.word_count), 32'(vecs[v].expCount));
      checkOutput("vec_valid_idle", 32'(bus.data_valid), 32'd0);
    end

    // Three words in one frame.
    sbQueue.push_back(8'h12);
    sbQueue.push_back(8'h34);
    sbQueue.push_back(8'h56);
    startFrame();
    sendBits(8'h12, 8);
    sendBits(8'h34, 8);
    sendBits(8'h56, 8);
    endFrame(1'b0);
    checkOutput("b2b_word_count", 32'(bus.word_count), 32'd3);

    // Overrun: second word dropped while the first is held.
    resetDut();
    bus.data_ready = 1'b0;
    sbQueue.push_back(8'hC3);
    startFrame();
    sendBits(8'hC3, 8);
    sendBits(8'h3C, 8);
    checkOutput("ovr_data_out", 32'(bus.data_out), 32'hC3);
    checkOutput("ovr_data_valid", 32'(bus.data_valid), 32'd1);
    checkOutput("ovr_flag", 32'(bus.overrun), 32'd1);
    endFrame(1'b0);
    checkOutput("ovr_word_count", 32'(bus.word_count), 32'd2);
    bus.data_ready = 1'b1;
    tick();
    checkOutput("ovr_valid_after", 32'(bus.data_valid), 32'd0);
    checkOutput("ovr_sticky", 32'(bus.overrun), 32'd1);

    // New word completes on the same cycle the held word is accepted.
    resetDut();
    bus.data_ready = 1'b0;
    sbQueue.push_back(8'h11);
    startFrame();
    sendBits(8'h11, 8);
    sendBits(8'h22, 7);
    sbQueue.push_back(8'h22);
    bus.sclk_posedge = 1'b1;
    bus.mosi         = 1'b0;
    bus.data_ready   = 1'b1;
    tick();
    checkOutput("sim_data_out", 32'(bus.data_out), 32'h22);
    checkOutput("sim_data_valid", 32'(bus.data_valid), 32'd1);
    checkOutput("sim_overrun", 32'(bus.overrun), 32'd0);
    bus.sclk_posedge = 1'b0;
    tick();
    endFrame(1'b0);
    checkOutput("sim_word_count", 32'(bus.word_count), 32'd2);

    // Reset in the middle of a word, then pulses outside a frame.
    resetDut();
    bus.data_ready = 1'b1;
    startFrame();
    sendBits(8'hE0, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkAllZero("midreset");
    tick();
    checkOutput("midreset_no_fe", 32'(bus.framing_error), 32'd0);
    bus.cs_n = 1'b1;
    sendBits(8'hF0, 4);
    checkAllZero("idle_pulses");
    sbQueue.push_back(8'hAA);
    startFrame();
    sendBits(8'hAA, 8);
    endFrame(1'b0);
    checkOutput("post_reset_count", 32'(bus.word_count), 32'd1);

    tick();
    checkOutput("scoreboard_empty", 32'(sbQueue.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
